// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), LSB first,
//   one bit per clock through a single full-subtractor cell and a borrow FF.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   operation request, sampled only while idle
//   a, b    minuend / subtrahend, captured on the accepted start edge
//   busy    high while shifting and during the done cycle
//   done    one-cycle strobe, diff/borrow valid
//   diff    a - b modulo 2^WIDTH, held until the next result lands
//   borrow  final borrow-out (a < b), held with diff
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg_a;
    logic [WIDTH-1:0] sreg_b;
    logic [WIDTH-1:0] pres;
    logic             bff;
    logic [CW-1:0]    count;

    // full-subtractor cell on the operand LSBs
    logic a0, b0, d, bout;
    logic [WIDTH-1:0] pres_nxt;

    always_comb begin
        a0       = sreg_a[0];
        b0       = sreg_b[0];
        d        = a0 ^ b0 ^ bff;
        bout     = (~a0 & b0) | (~(a0 ^ b0) & bff);
        // result fills from the MSB end so after WIDTH shifts bit 0 sits at LSB
        pres_nxt = {d, pres[WIDTH-1:1]};
    end

    assign busy = (state == SHIFT) || (state == DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg_a <= '0;
            sreg_b <= '0;
            pres   <= '0;
            bff    <= 1'b0;
            count  <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg_a <= a;
                        sreg_b <= b;
                        bff    <= 1'b0;
                        count  <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_a <= sreg_a >> 1;
                    sreg_b <= sreg_b >> 1;
                    pres   <= pres_nxt;
                    bff    <= bout;
                    if (count == LAST) begin
                        // final shift: publish the completed result
                        diff   <= pres_nxt;
                        borrow <= bout;
                        state  <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock. It uses a single full-subtractor cell (XOR difference, borrow logic) with a registered borrow flip-flop. It is the subtraction counterpart to the lab's half/full adder blocks. Operands load on a start pulse, and the result is presented with a one-cycle done strobe.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk     input   1      rising-edge clock
rst     input   1      synchronous, active-high reset
start   input   1      request; sampled only in IDLE
a       input   WIDTH  minuend; captured on accepted start
b       input   WIDTH  subtrahend; captured on accepted start
busy    output  1      high while in SHIFT or DONE
done    output  1      one-cycle strobe; result valid
diff    output  WIDTH  a - b modulo 2^WIDTH; held until next result
borrow  output  1      1 when a < b (unsigned); held with diff

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: at any posedge clk with rst=1, the block does all of the following:
  - state <= IDLE
  - busy, done, diff, borrow <= 0
  - internal operand, partial-result, borrow-FF and counter registers <= 0
  - rst overrides start.
- Reset mid-operation: the same clear applies. The pending operation is abandoned, and no done strobe ever occurs for it.
- State IDLE: busy=0, done=0.
  - start=1 at an edge: capture a into sreg_a and b into sreg_b, clear the borrow FF and count, go to SHIFT.
  - start=0: stay in IDLE.
- State SHIFT: busy=1. Each edge does the following:
  - Compute d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin), where a0/b0 are the sreg LSBs and bin is the borrow FF.
  - Shift sreg_a and sreg_b right by one.
  - Shift the partial-result register right, inserting d at the MSB.
  - Load bout into the borrow FF and increment count.
- SHIFT exit: on the edge where count == WIDTH-1 (the WIDTH-th shift), also do the following:
  - Load diff with the completed result (including the final d).
  - Load borrow with the final bout.
  - Go to DONE.
- State DONE: busy=1, done=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- start handling outside IDLE: start is ignored in SHIFT and DONE. It is neither queued nor does it disturb operands.
- Latency: start is accepted at edge E0. Shifts occur at E1..E_WIDTH. done is high in the cycle following E_WIDTH (i.e. WIDTH+1 cycles after acceptance).
- Back-to-back throughput: the earliest next accept is the edge after DONE, giving one op per WIDTH+2 cycles.
- Output stability:
  - diff and borrow change only on the edge entering DONE (or on reset).
  - They stay stable through IDLE and the next SHIFT until the new result lands.
  - a and b may change freely after the accept edge.
- Arithmetic: all unsigned, modulo 2^WIDTH.
  - borrow is the final borrow-out and equals (a < b).
  - Equal operands give diff=0, borrow=0.
- Counter: width is clog2(WIDTH), and it never wraps past WIDTH-1 in SHIFT.

Test Plan:
- Nominal (WIDTH=8): a=100, b=37, start pulse → done exactly 9 cycles after the accept edge, with diff=63, borrow=0. busy is high from the cycle after accept through the done cycle.
- Underflow: a=5, b=9 → diff=252, borrow=1. Also a=0, b=1 → diff=255, borrow=1.
- Boundaries:
  - a=255, b=255 → diff=0, borrow=0.
  - a=0, b=0 → diff=0, borrow=0.
  - a=255, b=0 → diff=255, borrow=0.
  - Exhaustive sweep of all 65536 pairs vs a reference model (a-b)&255, borrow=(a<b).
- start while busy: accept a=50, b=20, then pulse start with a=1, b=2 during SHIFT and again during DONE → single result diff=30, borrow=0, single done strobe. Block returns to IDLE.
- Reset mid-op: accept a=200, b=100, assert rst for 1 cycle after 4 shifts → next cycle busy=0, diff=0, borrow=0, and no done strobe follows. A subsequent op a=10, b=3 yields diff=7.
- Back-to-back with result hold: start held high continuously with a=9, b=4 then a=4, b=9 → accepts spaced 10 cycles apart. Results are 5/0 then 251/1. diff holds 5 until the edge entering the second DONE.
